// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: instruction field positions,
// opcode values, FSM state encoding and opcode classification.
package cpu_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RS_MSB  = 26;
  localparam int RS_LSB  = 22;
  localparam int RT_MSB  = 21;
  localparam int RT_LSB  = 17;
  localparam int RD_MSB  = 16;
  localparam int RD_LSB  = 12;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUBI = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_SHL  = 5'd3;
  localparam logic [4:0] OP_BEQ  = 5'd4;
  localparam logic [4:0] OP_JUMP = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT
  } state_t;

  // Opcodes that produce a register result and therefore take the WB cycle.
  function automatic logic is_alu_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUBI, OP_ADDI, OP_SHL, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result for the register-writing opcodes plus the
// operand-equality flag used by BEQ.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              eq
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUBI: result = a - imm;
      OP_ADDI: result = a + imm;
      OP_SHL:  result = a << b[SH_W-1:0];
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/cpu_mc_param.sv
// Multi-cycle CPU: FETCH/DECODE/EXEC/WB sequencer with run/step control,
// inline register file and instruction memory loaded through a write port.
module cpu_mc_param
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DISP_REG   = 8,
  localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              control,
  input  logic              step,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              instr_done,
  output logic [15:0]       disp_val,
  output logic [2:0]        state_dbg
);

  localparam logic [4:0] DISP_IDX = 5'(DISP_REG);

  state_t state, state_n;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [32];
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, res_q, imm_ext, alu_res;
  logic              alu_eq;
  logic [4:0]        op, rs, rt, rd;
  logic [PC_W-1:0]   pc_inc, target;

  assign op      = ir[OP_MSB:OP_LSB];
  assign rs      = ir[RS_MSB:RS_LSB];
  assign rt      = ir[RT_MSB:RT_LSB];
  assign rd      = ir[RD_MSB:RD_LSB];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_MSB:IMM_LSB]};
  assign pc_inc  = pc + PC_W'(1);
  assign target  = imm_ext[PC_W-1:0];

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (op),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_ext),
    .result (alu_res),
    .eq     (alu_eq)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (control || step) state_n = ST_FETCH;
      ST_FETCH:  state_n = ST_DECODE;
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HALT)      state_n = ST_HALT;
        else if (is_alu_op(op)) state_n = ST_WB;
        else                    state_n = control ? ST_FETCH : ST_IDLE;
      end
      ST_WB:     state_n = control ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_n = ST_HALT;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Register 0 is never written, so reading it always yields zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_FETCH:  ir <= imem[pc];
        ST_DECODE: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
        end
        ST_EXEC: begin
          res_q <= alu_res;
          if (!is_alu_op(op) && op != OP_HALT)
            pc <= ((op == OP_BEQ && alu_eq) || op == OP_JUMP) ? target : pc_inc;
        end
        ST_WB: begin
          if (rd != 5'd0) regs[rd] <= res_q;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end

  // Loading is only allowed while the core is stopped, so it never races FETCH.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && halted) imem[prog_addr] <= prog_data;
  end

  assign halted     = (state == ST_IDLE) || (state == ST_HALT);
  assign instr_done = (state == ST_WB) || (state == ST_EXEC && !is_alu_op(op));
  assign dbg_rdata  = regs[dbg_raddr];
  assign disp_val   = regs[DISP_IDX][15:0];
  assign state_dbg  = state;

endmodule

// File: tb/tb_cpu_mc_param.sv
// Bench for cpu_mc_param: instruction-level reference model compared every
// cycle, plus directed programs with hand-computed results.
module tb_cpu_mc_param;

  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 16;
  localparam int PC_W       = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              control = 1'b0;
  logic              step = 1'b0;
  logic              prog_we = 1'b0;
  logic [PC_W-1:0]   prog_addr = '0;
  logic [31:0]       prog_data = '0;
  logic [4:0]        dbg_raddr = '0;
  logic [DATA_W-1:0] dbg_rdata;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic              instr_done;
  logic [15:0]       disp_val;
  logic [2:0]        state_dbg;

  cpu_mc_param #(.DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .DISP_REG(8)) dut (
    .clk(clk), .reset(reset), .control(control), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc), .halted(halted),
    .instr_done(instr_done), .disp_val(disp_val), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit sweep    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  logic [31:0] m_imem [IMEM_DEPTH];
  logic [31:0] m_regs [32];
  logic [PC_W-1:0] m_pc;
  int  m_mode;  // 0 stopped, 1 running an instruction, 2 halted by HALT
  int  m_cnt, m_lat;
  bit  m_valid = 1'b0;

  function automatic int lat_of(input logic [31:0] w);
    int op;
    op = int'(w[31:27]);
    return (op <= 3 || (op >= 6 && op <= 8)) ? 4 : 3;
  endfunction

  task automatic m_exec(input logic [31:0] w);
    logic [4:0] op, rs, rt, rd;
    logic [31:0] a, b, imm, v;
    logic [PC_W-1:0] nxt;
    bit wr;
    op = w[31:27]; rs = w[26:22]; rt = w[21:17]; rd = w[16:12];
    imm = {20'd0, w[11:0]};
    a = m_regs[rs]; b = m_regs[rt];
    nxt = m_pc + 4'd1;
    wr = 1'b1;
    v = '0;
    case (op)
      5'd0: v = a + b;
      5'd1: v = a - imm;
      5'd2: v = a + imm;
      5'd3: v = a << b[4:0];
      5'd6: v = a - b;
      5'd7: v = a & b;
      5'd8: v = a | b;
      5'd4: begin wr = 1'b0; if (a == b) nxt = imm[PC_W-1:0]; end
      5'd5: begin wr = 1'b0; nxt = imm[PC_W-1:0]; end
      5'd31: begin wr = 1'b0; nxt = m_pc; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = v;
    m_pc = nxt;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_mode = 0; m_pc = '0; m_cnt = 0; m_lat = 3;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (prog_we && m_mode != 1) m_imem[prog_addr] = prog_data;
      case (m_mode)
        0: if (control || step) begin
          m_mode = 1; m_cnt = 0; m_lat = lat_of(m_imem[m_pc]);
        end
        1: if (m_cnt == m_lat - 1) begin
          logic [31:0] w;
          w = m_imem[m_pc];
          m_exec(w);
          if (w[31:27] == 5'd31) m_mode = 2;
          else if (control) begin m_cnt = 0; m_lat = lat_of(m_imem[m_pc]); end
          else m_mode = 0;
        end else m_cnt++;
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc", 64'(pc), 64'(m_pc));
      check("halted", 64'(halted), 64'(m_mode != 1));
      check("instr_done", 64'(instr_done), 64'(m_mode == 1 && m_cnt == m_lat - 1));
      check("disp_val", 64'(disp_val), 64'(m_regs[8][15:0]));
      check("dbg_rdata", 64'(dbg_rdata), 64'(m_regs[dbg_raddr]));
    end
    if (instr_done) done_cnt++;
  end

  always @(posedge clk) begin
    if (sweep) begin
      #1 dbg_raddr = 5'($urandom_range(0, 31));
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] prog [IMEM_DEPTH];
  logic [31:0] nop_w  = 32'h5000_0000;
  logic [31:0] halt_w = 32'hF800_0000;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [11:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; control = 1'b0; step = 1'b0; prog_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = nop_w;
  endtask

  task automatic load_prog();
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = PC_W'(i); prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic wait_halted(input int max, input string name);
    int n;
    n = 0;
    while (!halted && n < max) begin tick(); n++; end
    check(name, 64'(halted), 64'd1);
  endtask

  task automatic dbg_check(input string name, input int r, input logic [31:0] exp);
    dbg_raddr = 5'(r);
    #1;
    check(name, 64'(dbg_rdata), 64'(exp));
  endtask

  task automatic step_pulse(input int width);
    step = 1'b1;
    repeat (width) tick();
    step = 1'b0;
  endtask

  // ---------------- directed programs ----------------
  initial begin
    do_reset();
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_halted", 64'(halted), 64'd1);
    check("rst_done", 64'(instr_done), 64'd0);
    dbg_check("rst_r8", 8, 32'd0);

    // sum into the display register
    fill_nop();
    prog[0] = enc(5'd2, 5'd0, 5'd0, 5'd8, 12'd5);
    prog[1] = enc(5'd2, 5'd0, 5'd0, 5'd9, 12'd3);
    prog[2] = enc(5'd0, 5'd8, 5'd9, 5'd8, 12'd0);
    prog[3] = halt_w;
    load_prog();
    sweep = 1'b1;
    control = 1'b1;
    tick();
    repeat (14) tick();
    check("p1_halt_exec_running", 64'(halted), 64'd0);
    check("p1_halt_exec_done", 64'(instr_done), 64'd1);
    tick();
    check("p1_halted_at_15", 64'(halted), 64'd1);
    check("p1_pc", 64'(pc), 64'd3);
    sweep = 1'b0;
    check("p1_disp", 64'(disp_val), 64'd8);
    dbg_check("p1_r9", 9, 32'd3);

    // taken branch skips the r3 writes
    do_reset();
    check("p2_rst_disp", 64'(disp_val), 64'd0);
    fill_nop();
    prog[0] = enc(5'd2, 5'd0, 5'd0, 5'd1, 12'd7);
    prog[1] = enc(5'd2, 5'd0, 5'd0, 5'd2, 12'd7);
    prog[2] = enc(5'd4, 5'd1, 5'd2, 5'd0, 12'd5);
    prog[3] = enc(5'd2, 5'd0, 5'd0, 5'd3, 12'd1);
    prog[4] = enc(5'd2, 5'd0, 5'd0, 5'd3, 12'd1);
    prog[5] = halt_w;
    load_prog();
    control = 1'b1;
    tick();
    wait_halted(80, "p2_timeout");
    check("p2_pc", 64'(pc), 64'd5);
    dbg_check("p2_r3", 3, 32'd0);
    dbg_check("p2_r1", 1, 32'd7);

    // ALU mix, jump, untaken branch, r0 discard, wrap-around SUBI
    do_reset();
    fill_nop();
    prog[0]  = enc(5'd2, 5'd0, 5'd0, 5'd1, 12'hF0);
    prog[1]  = enc(5'd2, 5'd0, 5'd0, 5'd2, 12'h3C);
    prog[2]  = enc(5'd7, 5'd1, 5'd2, 5'd3, 12'd0);
    prog[3]  = enc(5'd8, 5'd1, 5'd2, 5'd4, 12'd0);
    prog[4]  = enc(5'd6, 5'd2, 5'd1, 5'd5, 12'd0);
    prog[5]  = enc(5'd2, 5'd0, 5'd0, 5'd6, 12'd4);
    prog[6]  = enc(5'd3, 5'd1, 5'd6, 5'd7, 12'd0);
    prog[7]  = enc(5'd5, 5'd0, 5'd0, 5'd0, 12'd9);
    prog[8]  = enc(5'd2, 5'd0, 5'd0, 5'd10, 12'd1);
    prog[9]  = enc(5'd1, 5'd0, 5'd0, 5'd4, 12'd1);
    prog[10] = enc(5'd2, 5'd0, 5'd0, 5'd0, 12'd9);
    prog[11] = enc(5'd4, 5'd1, 5'd2, 5'd0, 12'd14);
    prog[12] = halt_w;
    load_prog();
    sweep = 1'b1;
    control = 1'b1;
    tick();
    wait_halted(200, "p3_timeout");
    sweep = 1'b0;
    check("p3_pc", 64'(pc), 64'd12);
    dbg_check("p3_and", 3, 32'h30);
    dbg_check("p3_sub_wrap", 5, 32'hFFFF_FF4C);
    dbg_check("p3_shl", 7, 32'hF00);
    dbg_check("p3_jump_skip", 10, 32'd0);
    dbg_check("p3_subi_ones", 4, 32'hFFFF_FFFF);
    dbg_check("p3_r0", 0, 32'd0);

    // single stepping
    do_reset();
    fill_nop();
    prog[0] = enc(5'd2, 5'd0, 5'd0, 5'd1, 12'd1);
    prog[1] = enc(5'd2, 5'd0, 5'd0, 5'd2, 12'd2);
    prog[2] = enc(5'd2, 5'd0, 5'd0, 5'd3, 12'd3);
    prog[3] = halt_w;
    load_prog();
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step_pulse(k == 1 ? 2 : 1);
      repeat (6) tick();
      check("step_idle", 64'(halted), 64'd1);
      check("step_pc", 64'(pc), 64'(k + 1));
    end
    check("step_done_count", 64'(done_cnt), 64'd3);
    dbg_check("step_r2", 2, 32'd2);

    // pc wraps from the last address
    do_reset();
    fill_nop();
    prog[0] = enc(5'd5, 5'd0, 5'd0, 5'd0, 12'd15);
    load_prog();
    step_pulse(1);
    repeat (5) tick();
    check("wrap_jump_pc", 64'(pc), 64'd15);
    step_pulse(1);
    repeat (5) tick();
    check("wrap_pc", 64'(pc), 64'd0);

    // reset during EXEC aborts ADD; load attempt while running is dropped
    do_reset();
    fill_nop();
    prog[0] = enc(5'd2, 5'd0, 5'd0, 5'd1, 12'd2);
    prog[1] = enc(5'd0, 5'd1, 5'd1, 5'd5, 12'd0);
    prog[2] = halt_w;
    load_prog();
    control = 1'b1;
    tick();
    tick();
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = halt_w;
    tick();
    prog_we = 1'b0;
    repeat (4) tick();
    check("abort_in_exec", 64'(instr_done), 64'd0);
    reset = 1'b1; control = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_pc", 64'(pc), 64'd0);
    dbg_check("abort_r5", 5, 32'd0);
    control = 1'b1;
    tick();
    wait_halted(60, "rerun_timeout");
    check("rerun_pc", 64'(pc), 64'd2);
    dbg_check("rerun_r5", 5, 32'd4);
    control = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
